// File: rtl/core_mem_arb_pkg.sv
// Shared core package for the memory arbiter.
// Holds the arbiter state encoding and the requester-select encoding so the
// RTL and any bench or checker bound to the debug state agree on one definition.
package core_mem_arb_pkg;

  // Arbiter FSM: IDLE arbitrates and issues; WAIT_I / WAIT_D hold the single
  // outstanding memory transaction until its response arrives.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } arb_state_e;

  // Which requester the IDLE arbitration picked.
  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } arb_sel_e;

endpackage

// File: rtl/core_mem_arb_if.sv
// Bus bundle between the core (fetch + data ports), the arbiter and the
// shared memory port.
//
// Handshake rules, identical on all three channels:
//   - A requester raises *_req with stable fields and holds both until it
//     sees the matching grant (*_gnt) high in the same cycle; that cycle is
//     the transfer.
//   - A response is a single-cycle *_rvalid pulse; there is no back-pressure
//     on responses, the receiver must take it.
//
// Modports:
//   slave  : the arbiter's view (core requests in, memory requests out)
//   master : the environment's view (core + memory side)
interface core_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Fetch channel
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_kill;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  // Data (load/store) channel
  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // Shared memory channel
  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, i_kill,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output i_req, i_addr, i_kill,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/core_mem_arb.sv
// Fetch/data arbiter onto a single memory port, one transaction in flight.
//
// Data normally wins a simultaneous request; after STARVE_MAX consecutive
// data grants taken while fetch was waiting, fetch is forced through. A
// pipeline flush (i_kill) suppresses the fetch response still in flight.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   bus (slave)     fetch, data and memory channels (see core_mem_arb_if)
//   dbg_state       current FSM state
//   dbg_starve_cnt  consecutive fetch losses
module core_mem_arb
  import core_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  core_mem_arb_if.slave    bus,
  output arb_state_e       dbg_state,
  output logic [CNT_W-1:0] dbg_starve_cnt
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_q;
  logic             kill_q;

  arb_sel_e          sel;
  logic              starved;
  logic              mem_req_c, mem_we_c;
  logic [BE_W-1:0]   mem_be_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              i_gnt_c, d_gnt_c, i_rvalid_c, d_rvalid_c;

  // Data wins unless fetch is also waiting and has lost STARVE_MAX times.
  assign starved = (starve_q == STARVE_LIM);
  assign sel     = (bus.d_req && !(bus.i_req && starved)) ? SEL_D : SEL_I;

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_be_c    = '0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    i_gnt_c     = 1'b0;
    d_gnt_c     = 1'b0;
    i_rvalid_c  = 1'b0;
    d_rvalid_c  = 1'b0;

    case (state_q)
      IDLE: begin
        mem_req_c = bus.i_req | bus.d_req;
        if (sel == SEL_D) begin
          mem_we_c    = bus.d_we;
          mem_be_c    = bus.d_be;
          mem_addr_c  = bus.d_addr;
          mem_wdata_c = bus.d_wdata;
        end else begin
          // Fetches are always full-word reads.
          mem_be_c   = '1;
          mem_addr_c = bus.i_addr;
        end
        i_gnt_c = (sel == SEL_I) && bus.i_req && bus.mem_gnt;
        d_gnt_c = (sel == SEL_D) && bus.mem_gnt;
        if (i_gnt_c)      state_d = WAIT_I;
        else if (d_gnt_c) state_d = WAIT_D;
      end
      WAIT_I: begin
        if (bus.mem_rvalid) begin
          // A kill arriving with the response still discards it.
          i_rvalid_c = !(kill_q || bus.i_kill);
          state_d    = IDLE;
        end
      end
      WAIT_D: begin
        if (bus.mem_rvalid) begin
          d_rvalid_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs stay quiet for the whole time reset is asserted, not just
    // once the state register has been cleared.
    if (rst) begin
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      mem_be_c    = '0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      i_gnt_c     = 1'b0;
      d_gnt_c     = 1'b0;
      i_rvalid_c  = 1'b0;
      d_rvalid_c  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (i_gnt_c)
        starve_q <= '0;
      else if (d_gnt_c && bus.i_req && !starved)
        starve_q <= starve_q + CNT_W'(1);

      // Leaving WAIT_I takes priority so a stale kill never leaks into the
      // next fetch.
      if (state_q == WAIT_I && bus.mem_rvalid)
        kill_q <= 1'b0;
      else if (bus.i_kill && (state_q == WAIT_I || i_gnt_c))
        kill_q <= 1'b1;
    end
  end

  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_be    = mem_be_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.i_gnt     = i_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.i_rvalid  = i_rvalid_c;
  assign bus.d_rvalid  = d_rvalid_c;
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_core_mem_arb.sv
// Bench for core_mem_arb: directed scenarios plus a randomised data-only run.
// Responses are tracked with a scoreboard of {is_data, rdata} entries pushed
// at grant time and popped by a monitor when an rvalid appears.
module tb_core_mem_arb;
  import core_mem_arb_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = $clog2(STARVE_MAX + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb_state_e       dbg_state;
  logic [CNT_W-1:0] dbg_starve_cnt;

  core_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  core_mem_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- scoreboard ----------------
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] mon_exp, mon_got;

  always @(negedge clk) begin
    if (bus.i_rvalid === 1'b1 || bus.d_rvalid === 1'b1) begin
      n_checks++;
      if (bus.i_rvalid === 1'b1 && bus.d_rvalid === 1'b1)
        $display("FAIL resp_both: i_rvalid and d_rvalid both high, want one");
      else if (exp_q.size() == 0)
        $display("FAIL resp_unexpected: got i_rvalid=%b d_rvalid=%b, want none",
                 bus.i_rvalid, bus.d_rvalid);
      else begin
        mon_exp = exp_q.pop_front();
        mon_got = {bus.d_rvalid, (bus.d_rvalid === 1'b1) ? bus.d_rdata : bus.i_rdata};
        if (mon_got !== mon_exp)
          $display("FAIL resp_data: got {d,data}=%h want %h", mon_got, mon_exp);
        else
          n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req      = 1'b0;
    bus.i_addr     = '0;
    bus.i_kill     = 1'b0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_be       = '0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic drive_fetch(input logic [ADDR_W-1:0] a);
    bus.i_req  = 1'b1;
    bus.i_addr = a;
  endtask

  task automatic drive_data(input logic we, input logic [3:0] be,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_be    = be;
    bus.d_addr  = a;
    bus.d_wdata = wd;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000",
               {bus.mem_req, bus.mem_we, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid});
    else n_pass++;
    n_checks++;
    if (dbg_state !== IDLE || dbg_starve_cnt !== '0)
      $display("FAIL reset_state: got state=%0d starve=%0d want 0/0", dbg_state, dbg_starve_cnt);
    else n_pass++;
    idle_inputs();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_priority();
    drive_fetch(32'h100);
    drive_data(1'b0, 4'hf, 32'h200, '0);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.mem_req, bus.mem_we} !== 4'b0110)
      $display("FAIL prio_data_wins: got i/d/req/we=%b want 0110",
               {bus.i_gnt, bus.d_gnt, bus.mem_req, bus.mem_we});
    else n_pass++;
    n_checks++;
    if (bus.mem_addr !== 32'h200)
      $display("FAIL prio_data_addr: got %h want 00000200", bus.mem_addr);
    else n_pass++;
    exp_q.push_back({1'b1, 32'hCAFE0200});
    step();
    bus.d_req = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE0200;
    @(negedge clk);
    n_checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.mem_req} !== 3'b000 || dbg_state !== WAIT_D)
      $display("FAIL prio_wait_quiet: got i/d/req=%b state=%0d want 000/WAIT_D",
               {bus.i_gnt, bus.d_gnt, bus.mem_req}, dbg_state);
    else n_pass++;
    n_checks++;
    if (dbg_starve_cnt !== 3'd1)
      $display("FAIL prio_starve_inc: got %0d want 1", dbg_starve_cnt);
    else n_pass++;
    step();
    bus.mem_rvalid = 1'b0;
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL prio_d_resp_seen: got %0d pending want 0", exp_q.size());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.mem_req, bus.mem_we} !== 4'b1010 ||
        bus.mem_addr !== 32'h100 || bus.mem_be !== 4'hf)
      $display("FAIL prio_fetch_next: got i/d/req/we=%b addr=%h be=%h want 1010/100/f",
               {bus.i_gnt, bus.d_gnt, bus.mem_req, bus.mem_we}, bus.mem_addr, bus.mem_be);
    else n_pass++;
    exp_q.push_back({1'b0, 32'hF00D0100});
    step();
    bus.i_req = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hF00D0100;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== WAIT_I || dbg_starve_cnt !== '0)
      $display("FAIL prio_fetch_wait: got state=%0d starve=%0d want WAIT_I/0",
               dbg_state, dbg_starve_cnt);
    else n_pass++;
    step();
    idle_inputs();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL prio_i_resp_seen: got %0d pending want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_starve();
    logic [DATA_W-1:0] rd;
    drive_fetch(32'h300);
    drive_data(1'b0, 4'hf, 32'h400, '0);
    bus.mem_gnt = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (k < 5) begin
        if ({bus.i_gnt, bus.d_gnt} !== 2'b01 || dbg_starve_cnt !== CNT_W'(k - 1))
          $display("FAIL starve_data_%0d: got i/d=%b cnt=%0d want 01/%0d",
                   k, {bus.i_gnt, bus.d_gnt}, dbg_starve_cnt, k - 1);
        else n_pass++;
      end else begin
        if ({bus.i_gnt, bus.d_gnt} !== 2'b10 || dbg_starve_cnt !== CNT_W'(STARVE_MAX))
          $display("FAIL starve_fetch_forced: got i/d=%b cnt=%0d want 10/%0d",
                   {bus.i_gnt, bus.d_gnt}, dbg_starve_cnt, STARVE_MAX);
        else n_pass++;
      end
      rd = 32'h5A5A0000 + DATA_W'(k);
      exp_q.push_back({(k < 5), rd});
      step();
      if (k == 5) bus.i_req = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = rd;
      step();
      bus.mem_rvalid = 1'b0;
    end
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (dbg_starve_cnt !== '0 || exp_q.size() != 0)
      $display("FAIL starve_cleared: got cnt=%0d pending=%0d want 0/0",
               dbg_starve_cnt, exp_q.size());
    else n_pass++;
    step();
  endtask

  task automatic test_kill();
    // Kill while waiting.
    drive_fetch(32'h500);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.i_gnt !== 1'b1) $display("FAIL kill_a_gnt: got %b want 1", bus.i_gnt);
    else n_pass++;
    step();
    bus.i_req = 1'b0; bus.i_kill = 1'b1;
    step();
    bus.i_kill = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'hDEADBEEF)
      $display("FAIL kill_a_masked: got rvalid=%b rdata=%h want 0/deadbeef",
               bus.i_rvalid, bus.i_rdata);
    else n_pass++;
    step();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== IDLE) $display("FAIL kill_a_idle: got %0d want IDLE", dbg_state);
    else n_pass++;
    // Kill in the grant cycle.
    step();
    drive_fetch(32'h504);
    bus.i_kill = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.i_gnt !== 1'b1) $display("FAIL kill_b_gnt: got %b want 1", bus.i_gnt);
    else n_pass++;
    step();
    bus.i_req = 1'b0; bus.i_kill = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h11112222;
    @(negedge clk);
    n_checks++;
    if (bus.i_rvalid !== 1'b0) $display("FAIL kill_b_masked: got %b want 0", bus.i_rvalid);
    else n_pass++;
    step();
    bus.mem_rvalid = 1'b0;
    // Kill in IDLE with no grant does nothing; next fetch is delivered.
    bus.i_kill = 1'b1;
    step();
    bus.i_kill = 1'b0;
    drive_fetch(32'h508);
    @(negedge clk);
    n_checks++;
    if (bus.i_gnt !== 1'b1) $display("FAIL kill_c_gnt: got %b want 1", bus.i_gnt);
    else n_pass++;
    exp_q.push_back({1'b0, 32'h33334444});
    step();
    bus.i_req = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h33334444;
    step();
    idle_inputs();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL kill_c_delivered: got %0d pending want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_write_stall();
    drive_data(1'b1, 4'b0011, 32'h600, 32'h12345678);
    bus.mem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.mem_req, bus.mem_we, bus.d_gnt} !== 3'b110 ||
          {bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {4'b0011, 32'h600, 32'h12345678})
        $display("FAIL stall_hold_%0d: got req/we/gnt=%b be=%h addr=%h wd=%h want 110/3/600/12345678",
                 c, {bus.mem_req, bus.mem_we, bus.d_gnt}, bus.mem_be, bus.mem_addr, bus.mem_wdata);
      else n_pass++;
      step();
    end
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.d_gnt !== 1'b1) $display("FAIL stall_gnt: got %b want 1", bus.d_gnt);
    else n_pass++;
    exp_q.push_back({1'b1, 32'hA5A5A5A5});
    step();
    bus.d_req = 1'b0; bus.mem_gnt = 1'b0;
    bus.i_kill = 1'b1;  // must not affect a data response
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    n_checks++;
    if (bus.d_rvalid !== 1'b1) $display("FAIL stall_rvalid: got %b want 1", bus.d_rvalid);
    else n_pass++;
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    drive_data(1'b0, 4'hf, 32'h700, '0);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.d_gnt !== 1'b1) $display("FAIL rmid_gnt: got %b want 1", bus.d_gnt);
    else n_pass++;
    step();
    bus.d_req = 1'b0; bus.mem_gnt = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dbg_state !== IDLE) $display("FAIL rmid_async: got %0d want IDLE", dbg_state);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    n_checks++;
    if (bus.d_rvalid !== 1'b0 || dbg_state !== IDLE)
      $display("FAIL rmid_late_rvalid: got rvalid=%b state=%0d want 0/IDLE",
               bus.d_rvalid, dbg_state);
    else n_pass++;
    step();
    bus.mem_rvalid = 1'b0;
    drive_data(1'b0, 4'hf, 32'h704, '0);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.d_gnt !== 1'b1) $display("FAIL rmid_regrant: got %b want 1", bus.d_gnt);
    else n_pass++;
    exp_q.push_back({1'b1, 32'h07040704});
    step();
    bus.d_req = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h07040704;
    step();
    idle_inputs();
  endtask

  task automatic test_idle_rvalid();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77777777;
    @(negedge clk);
    n_checks++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.mem_req} !== 3'b000)
      $display("FAIL idle_rvalid_ignored: got i/d/req=%b want 000",
               {bus.i_rvalid, bus.d_rvalid, bus.mem_req});
    else n_pass++;
    step();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== IDLE) $display("FAIL idle_rvalid_state: got %0d want IDLE", dbg_state);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] rd;
    int stall, lat;
    for (int t = 0; t < 8; t++) begin
      a     = {$urandom_range(0, 65535), 2'b00} & 32'h0003_FFFC;
      rd    = $urandom;
      stall = $urandom_range(0, 2);
      lat   = $urandom_range(1, 3);
      drive_data(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), a, $urandom);
      bus.mem_gnt = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        n_checks++;
        if ({bus.mem_req, bus.d_gnt} !== 2'b10)
          $display("FAIL b2b_stall_%0d: got req/gnt=%b want 10", t, {bus.mem_req, bus.d_gnt});
        else n_pass++;
        step();
      end
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.d_gnt !== 1'b1 || bus.mem_addr !== a)
        $display("FAIL b2b_gnt_%0d: got gnt=%b addr=%h want 1/%h", t, bus.d_gnt, bus.mem_addr, a);
      else n_pass++;
      exp_q.push_back({1'b1, rd});
      step();
      bus.d_req = 1'b0; bus.mem_gnt = 1'b0;
      for (int l = 1; l < lat; l++) step();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = rd;
      step();
      bus.mem_rvalid = 1'b0;
    end
    idle_inputs();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL b2b_drained: got %0d pending want 0", exp_q.size());
    else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_priority();
    test_starve();
    test_kill();
    test_write_stall();
    test_reset_mid();
    test_idle_rvalid();
    test_back_to_back();
    step();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL final_queue: got %0d pending want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_mem_arb.md
CORE_MEM_ARB -- requirements
Module: core_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; byte-enable width is DATA_W/8.
REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning consecutive fetch losses before fetch is forced to win.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_req  input  1  fetch request, held until i_gnt.
REQ-007 i_addr  input  ADDR_W  fetch address.
REQ-008 i_kill  input  1  discard the outstanding fetch response (pipeline flush).
REQ-009 i_gnt / i_rvalid  output  1 each  fetch accepted / fetch data valid.
REQ-010 i_rdata  output  DATA_W  fetch data.
REQ-011 d_req, d_we  input  1 each  data request (held until d_gnt) / write.
REQ-012 d_be, d_addr, d_wdata  input  DATA_W/8, ADDR_W, DATA_W  data byte enables, address, write data.
REQ-013 d_gnt / d_rvalid  output  1 each  data accepted / data response (reads and writes).
REQ-014 d_rdata  output  DATA_W  load data.
REQ-015 mem_req, mem_we, mem_be, mem_addr, mem_wdata  output  1, 1, DATA_W/8, ADDR_W, DATA_W  shared memory request.
REQ-016 mem_gnt, mem_rvalid, mem_rdata  input  1, 1, DATA_W  memory accept, response valid, read data.

Function
REQ-017 SHALL implement states IDLE, WAIT_I and WAIT_D, with at most one memory transaction outstanding.
REQ-018 IDLE: arbitration and mem_req are combinational; mem_req = i_req | d_req.
REQ-019 IDLE selection: data wins when both requesters are active, unless starve_cnt == STARVE_MAX, in which case fetch wins; a lone requester always wins.
REQ-020 mem_we, mem_be, mem_addr and mem_wdata SHALL carry the selected requester's fields; for fetch, mem_we = 0 and mem_be = all ones.
REQ-021 i_gnt/d_gnt = (state IDLE) & selected & mem_gnt, combinationally in the same cycle; the next state becomes WAIT_I or WAIT_D.
REQ-022 In WAIT_I/WAIT_D, mem_req, i_gnt and d_gnt SHALL be 0.
REQ-023 In WAIT_x with mem_rvalid = 1, the response SHALL pass combinationally to the owner's rvalid/rdata, and the next state is IDLE; the next grant is no earlier than the following cycle (minimum 2 cycles per transaction).
REQ-024 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment, saturating, on each d_gnt cycle with i_req = 1, and SHALL clear on i_gnt.
REQ-025 A kill_pend flag SHALL be set when i_kill = 1 in WAIT_I, or together with i_gnt; it masks i_rvalid for that response and clears on leaving WAIT_I.
REQ-026 i_kill SHALL have no effect in IDLE without i_gnt, or in WAIT_D.
REQ-027 mem_rvalid in IDLE SHALL be ignored; no rvalid is forwarded.
REQ-028 i_rdata/d_rdata SHALL equal mem_rdata unconditionally; only the rvalid outputs are gated.
REQ-029 When no requester is active, mem_req = 0 and the data fields are don't-care.

Reset
REQ-030 On rst: state = IDLE, starve_cnt = 0, kill_pend = 0, asynchronously.
REQ-031 All outputs SHALL be 0 (data fields may be don't-care) while rst is high.
REQ-032 Reset mid-transaction SHALL drop the outstanding response; a late mem_rvalid is ignored per REQ-027.

Structure
REQ-033 The state enum (IDLE, WAIT_I, WAIT_D) SHALL live in the shared core package, alongside the other core typedefs.
REQ-034 The block SHALL be a single module with no sub-modules; the starvation counter stays inline.

Verification
REQ-035 Both request at 0x100 (fetch) and 0x200 (data), mem_gnt = 1 -> d_gnt cycle 0, d_rvalid on the mem_rvalid cycle, then i_gnt no earlier than the next cycle.
REQ-036 d_req held continuously with i_req, STARVE_MAX = 4, mem latency 1 -> 4 data grants, then i_gnt on the 5th arbitration, then starve_cnt = 0.
REQ-037 Fetch granted, i_kill pulsed in WAIT_I, mem_rvalid with rdata 0xDEADBEEF -> i_rvalid stays 0 and state returns to IDLE.
REQ-038 Data write d_be = 4'b0011, d_wdata = 0x12345678, mem_gnt low for 3 cycles -> mem fields stable and d_gnt = 0 until mem_gnt, d_rvalid on the response.
REQ-039 rst asserted in WAIT_D, mem_rvalid two cycles after release -> d_rvalid = 0, state IDLE, new request granted normally.
REQ-040 mem_rvalid pulsed in IDLE with no outstanding transaction -> i_rvalid = d_rvalid = 0, state unchanged.
